// File: rtl/nlow_event_encoder_pkg.sv
// Shared definitions for the active-low event encoder and its 3->8 decoder partner.
// idx2code is the line-to-code mapping both sides must agree on.
package nlow_enc_pkg;

    localparam int N_LINES = 8;
    localparam int CODE_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Line k maps to code 7-k, which for a 3-bit index is a bitwise inversion.
    function automatic logic [CODE_W-1:0] idx2code(input logic [CODE_W-1:0] i);
        return ~i;
    endfunction

endpackage

// File: rtl/nlow_event_encoder_rr_pick8.sv
// Combinational round-robin picker over 8 requests: rotate by ptr, take the
// first set bit, then rotate the found offset back into a line index.
module rr_pick8
    import nlow_enc_pkg::*;
(
    input  logic [N_LINES-1:0] req,
    input  logic [CODE_W-1:0]  ptr,
    output logic               any,
    output logic [CODE_W-1:0]  idx
);

    logic [2*N_LINES-1:0] dbl;
    logic [N_LINES-1:0]   rot;
    logic [CODE_W-1:0]    off;
    logic                 found;

    always_comb begin
        dbl   = {req, req};
        // rot[i] is req[(ptr+i) mod 8], so bit 0 is the highest-priority line.
        rot   = dbl[ptr +: N_LINES];
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < N_LINES; i++) begin
            if (!found && rot[i]) begin
                off   = CODE_W'(i);
                found = 1'b1;
            end
        end
        any = found;
        idx = ptr + off;
    end

endmodule

// File: rtl/nlow_event_encoder.sv
// Serialises new assertions on 8 active-low request lines into 3-bit codes on a
// valid/ready stream, with per-line pending latches, round-robin order and sticky overflow.
module nlow_event_encoder
    import nlow_enc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LINES-1:0] in_n,
    input  logic               clr_i,
    output logic [CODE_W-1:0]  code_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [N_LINES-1:0] pending_o,
    output logic               ovf_o,
    output state_t             dbg_state,
    output logic [CODE_W-1:0]  dbg_ptr
);

    // Handshake: a code transfers on every rising edge where valid_o && ready_i.
    // While valid_o is high and ready_i is low, code_o is held unchanged.

    state_t              state_q, state_d;
    logic [N_LINES-1:0]  prev_n_q;
    logic [N_LINES-1:0]  pending_q, pending_d;
    logic                ovf_q, ovf_d;
    logic [CODE_W-1:0]   ptr_q, ptr_d;
    logic [CODE_W-1:0]   sel_q, sel_d;
    logic [CODE_W-1:0]   code_q, code_d;

    logic [N_LINES-1:0]  rise;
    logic [N_LINES-1:0]  consumed;
    logic [N_LINES-1:0]  cand;
    logic                hs;
    logic [CODE_W-1:0]   search_ptr;
    logic                pick_any;
    logic [CODE_W-1:0]   pick_idx;

    assign rise     = prev_n_q & ~in_n;
    assign hs       = (state_q == HOLD) && ready_i;
    assign consumed = hs ? (N_LINES'(1) << sel_q) : '0;
    assign cand     = pending_q & ~consumed;
    // On a handshake the search starts just past the line being retired, so the
    // same-edge reload already honours the advanced pointer.
    assign search_ptr = hs ? sel_q + 3'd1 : ptr_q;

    rr_pick8 u_pick (
        .req (cand),
        .ptr (search_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        pending_d = pending_q;
        ovf_d     = ovf_q;
        if (clr_i) begin
            pending_d = '0;
            ovf_d     = 1'b0;
        end else begin
            for (int k = 0; k < N_LINES; k++) begin
                if (rise[k]) begin
                    pending_d[k] = 1'b1;
                end else if (consumed[k]) begin
                    pending_d[k] = 1'b0;
                end
            end
            ovf_d = ovf_q | (|(rise & pending_q & ~consumed));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prev_n_q  <= '1;
            pending_q <= '0;
            ovf_q     <= 1'b0;
            ptr_q     <= '0;
            sel_q     <= '0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            prev_n_q  <= in_n;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            code_q    <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (clr_i) begin
                    code_d = '0;
                end else if (pick_any) begin
                    state_d = HOLD;
                    sel_d   = pick_idx;
                    code_d  = idx2code(pick_idx);
                end
            end
            HOLD: begin
                // A clear abandons the held code without advancing the pointer.
                if (clr_i) begin
                    state_d = IDLE;
                    code_d  = '0;
                end else if (hs) begin
                    ptr_d = sel_q + 3'd1;
                    if (pick_any) begin
                        sel_d  = pick_idx;
                        code_d = idx2code(pick_idx);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_o   = (state_q == HOLD);
        code_o    = code_q;
        pending_o = pending_q;
        ovf_o     = ovf_q;
        dbg_state = state_q;
        dbg_ptr   = ptr_q;
    end

endmodule

// File: tb/tb_nlow_event_encoder.sv
// Bench for nlow_event_encoder: vector table, directed corner sequences and a
// randomized run against a behavioural model.
module tb_nlow_event_encoder;
    import nlow_enc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_n = 8'hFF;
    logic       clr_i = 1'b0;
    logic       ready_i = 1'b0;
    logic [2:0] code_o;
    logic       valid_o;
    logic [7:0] pending_o;
    logic       ovf_o;
    state_t     dbg_state;
    logic [2:0] dbg_ptr;

    int total = 0;
    int bad = 0;

    logic [2:0] obs_q[$];
    logic [2:0] exp_q[$];

    // model state
    logic [7:0] m_prev;
    logic [7:0] m_pend;
    logic       m_ovf;
    int         m_held;
    int         m_ptr;

    typedef struct {
        logic [7:0] in_n;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [2:0] ec;
        logic [7:0] ep;
        logic       eo;
        logic [2:0] eptr;
    } vec_t;

    vec_t tbl[20];

    nlow_event_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_n      (in_n),
        .clr_i     (clr_i),
        .code_o    (code_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .pending_o (pending_o),
        .ovf_o     (ovf_o),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) obs_q.push_back(code_o);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int find_from(input int ptr, input logic [7:0] set);
        for (int i = 0; i < 8; i++) begin
            if (set[(ptr + i) % 8]) return (ptr + i) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_prev = 8'hFF;
        m_pend = 8'h00;
        m_ovf  = 1'b0;
        m_held = -1;
        m_ptr  = 0;
    endtask

    task automatic model_step(input logic [7:0] a_in, input logic rdy, input logic clr);
        logic [7:0] new_pend;
        logic [7:0] avail;
        bit hs;
        bit rise;
        bit cons;
        hs = (m_held >= 0) && rdy;
        new_pend = m_pend;
        for (int k = 0; k < 8; k++) begin
            rise = m_prev[k] && !a_in[k];
            cons = hs && (m_held == k);
            if (clr) new_pend[k] = 1'b0;
            else if (rise) begin
                if (m_pend[k] && !cons) m_ovf = 1'b1;
                new_pend[k] = 1'b1;
            end else if (cons) new_pend[k] = 1'b0;
        end
        if (clr) m_ovf = 1'b0;
        if (m_held < 0) begin
            if (!clr) m_held = find_from(m_ptr, m_pend);
        end else if (clr) begin
            m_held = -1;
        end else if (hs) begin
            m_ptr = (m_held + 1) % 8;
            avail = m_pend;
            avail[m_held] = 1'b0;
            m_held = find_from(m_ptr, avail);
        end
        m_pend = new_pend;
        m_prev = a_in;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        in_n    = 8'hFF;
        clr_i   = 1'b0;
        ready_i = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] dec;
        int li;
        int ec;

        tbl[0]  = '{8'hFE, 1'b1, 1'b0, 1'b0, 3'd0, 8'h01, 1'b0, 3'd0};
        tbl[1]  = '{8'hFE, 1'b1, 1'b0, 1'b1, 3'd7, 8'h01, 1'b0, 3'd0};
        tbl[2]  = '{8'hFE, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd1};
        tbl[3]  = '{8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd1};
        tbl[4]  = '{8'hAD, 1'b1, 1'b0, 1'b0, 3'd0, 8'h52, 1'b0, 3'd1};
        tbl[5]  = '{8'hAD, 1'b1, 1'b0, 1'b1, 3'd6, 8'h52, 1'b0, 3'd1};
        tbl[6]  = '{8'hAD, 1'b1, 1'b0, 1'b1, 3'd3, 8'h50, 1'b0, 3'd2};
        tbl[7]  = '{8'hAD, 1'b1, 1'b0, 1'b1, 3'd1, 8'h40, 1'b0, 3'd5};
        tbl[8]  = '{8'hAD, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd7};
        tbl[9]  = '{8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd7};
        tbl[10] = '{8'hEF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h10, 1'b0, 3'd7};
        tbl[11] = '{8'hEF, 1'b1, 1'b0, 1'b1, 3'd3, 8'h10, 1'b0, 3'd7};
        tbl[12] = '{8'hEF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd5};
        tbl[13] = '{8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd5};
        tbl[14] = '{8'hAD, 1'b1, 1'b0, 1'b0, 3'd0, 8'h52, 1'b0, 3'd5};
        tbl[15] = '{8'hAD, 1'b1, 1'b0, 1'b1, 3'd1, 8'h52, 1'b0, 3'd5};
        tbl[16] = '{8'hAD, 1'b1, 1'b0, 1'b1, 3'd6, 8'h12, 1'b0, 3'd7};
        tbl[17] = '{8'hAD, 1'b1, 1'b0, 1'b1, 3'd3, 8'h10, 1'b0, 3'd2};
        tbl[18] = '{8'hAD, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd5};
        tbl[19] = '{8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd5};

        // reset values
        do_reset();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_code", 32'(code_o), 32'd0);
        check("rst_pending", 32'(pending_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        check("rst_ptr", 32'(dbg_ptr), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // single line, then lines 1,4,6 from ptr 1 and from ptr 5
        for (int i = 0; i < 20; i++) begin
            in_n    = tbl[i].in_n;
            ready_i = tbl[i].rdy;
            clr_i   = tbl[i].clr;
            step();
            check($sformatf("row%0d_valid", i), 32'(valid_o), 32'(tbl[i].ev));
            check($sformatf("row%0d_pending", i), 32'(pending_o), 32'(tbl[i].ep));
            check($sformatf("row%0d_ovf", i), 32'(ovf_o), 32'(tbl[i].eo));
            check($sformatf("row%0d_ptr", i), 32'(dbg_ptr), 32'(tbl[i].eptr));
            if (tbl[i].ev) check($sformatf("row%0d_code", i), 32'(code_o), 32'(tbl[i].ec));
        end

        // held code is not preempted by a later arrival
        obs_q.delete();
        ready_i = 1'b0;
        in_n = 8'hFB;
        step();
        step();
        check("hold_valid", 32'(valid_o), 32'd1);
        check("hold_code", 32'(code_o), 32'd5);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("hold%0d_valid", i), 32'(valid_o), 32'd1);
            check($sformatf("hold%0d_code", i), 32'(code_o), 32'd5);
        end
        in_n = 8'hFA;
        step();
        step();
        check("nopreempt_code", 32'(code_o), 32'd5);
        check("nopreempt_pending", 32'(pending_o), 32'h05);
        ready_i = 1'b1;
        step();
        check("after_hs_valid", 32'(valid_o), 32'd1);
        check("after_hs_code", 32'(code_o), 32'd7);
        step();
        check("drain_valid", 32'(valid_o), 32'd0);
        check("drain_ptr", 32'(dbg_ptr), 32'd1);
        in_n = 8'hFF;
        ready_i = 1'b0;
        step();
        check("hold_obs_n", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() == 2) begin
            check("hold_obs0", 32'(obs_q[0]), 32'd5);
            check("hold_obs1", 32'(obs_q[1]), 32'd7);
        end

        // overflow on re-pulse of a pending line, then clear
        obs_q.delete();
        in_n = 8'hF7;
        step();
        in_n = 8'hFF;
        step();
        in_n = 8'hF7;
        step();
        check("ovf_set", 32'(ovf_o), 32'd1);
        check("ovf_pending", 32'(pending_o), 32'h08);
        check("ovf_code", 32'(code_o), 32'd4);
        clr_i = 1'b1;
        ready_i = 1'b1;
        in_n = 8'hF3;
        step();
        check("clr_ovf", 32'(ovf_o), 32'd0);
        check("clr_pending", 32'(pending_o), 32'h00);
        check("clr_valid", 32'(valid_o), 32'd0);
        check("clr_ptr", 32'(dbg_ptr), 32'd1);
        clr_i = 1'b0;
        ready_i = 1'b0;
        in_n = 8'hFF;
        step();
        check("post_clr_valid", 32'(valid_o), 32'd0);
        check("ovf_obs_n", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() == 1) check("ovf_obs0", 32'(obs_q[0]), 32'd4);

        // re-assert on the consuming edge: emitted twice, no overflow
        obs_q.delete();
        in_n = 8'hDF;
        step();
        step();
        check("reas_code", 32'(code_o), 32'd2);
        in_n = 8'hFF;
        step();
        in_n = 8'hDF;
        ready_i = 1'b1;
        step();
        check("reas_pending", 32'(pending_o), 32'h20);
        check("reas_ovf", 32'(ovf_o), 32'd0);
        step();
        check("reas_valid2", 32'(valid_o), 32'd1);
        check("reas_code2", 32'(code_o), 32'd2);
        step();
        check("reas_idle", 32'(valid_o), 32'd0);
        check("reas_obs_n", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() == 2) begin
            check("reas_obs0", 32'(obs_q[0]), 32'd2);
            check("reas_obs1", 32'(obs_q[1]), 32'd2);
        end
        ready_i = 1'b0;
        in_n = 8'hFF;
        step();

        // async reset mid-HOLD, lines still low at release
        in_n = 8'hD5;
        step();
        step();
        check("pre_rst_valid", 32'(valid_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(valid_o), 32'd0);
        check("arst_code", 32'(code_o), 32'd0);
        check("arst_pending", 32'(pending_o), 32'd0);
        check("arst_ovf", 32'(ovf_o), 32'd0);
        check("arst_ptr", 32'(dbg_ptr), 32'd0);
        step();
        check("arst_hold_pending", 32'(pending_o), 32'd0);
        rst_n = 1'b1;
        obs_q.delete();
        ready_i = 1'b1;
        step();
        check("rel_pending", 32'(pending_o), 32'h2A);
        repeat (8) step();
        exp_q.delete();
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd2);
        check("rel_obs_n", 32'(obs_q.size()), 32'd3);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            check("rel_obs", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        end
        check("rel_ovf", 32'(ovf_o), 32'd0);

        // randomized run against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 3) == 0) in_n[b] = ~in_n[b];
            end
            ready_i = ($urandom_range(0, 3) != 0);
            clr_i = ($urandom_range(0, 39) == 0);
            if (m_held >= 0 && ready_i) begin
                dec = ~(8'h01 << (3'd7 - code_o));
                li = -1;
                for (int i = 0; i < 8; i++) if (!dec[i]) li = i;
                check("rnd_decode", 32'(li), 32'(m_held));
            end
            model_step(in_n, ready_i, clr_i);
            step();
            check("rnd_valid", 32'(valid_o), 32'(m_held >= 0));
            check("rnd_pending", 32'(pending_o), 32'(m_pend));
            check("rnd_ovf", 32'(ovf_o), 32'(m_ovf));
            if (m_held >= 0) begin
                ec = 7 - m_held;
                check("rnd_code", 32'(code_o), 32'(ec));
            end
        end
        clr_i = 1'b0;
        ready_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
